// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two write-back sources,
// with a registered write stage, RAW hazard flag and saturating contention counter.
module regfile_wr_arbiter #(
  parameter int N     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             clr_cnt,
  input  logic             req0_valid,
  input  logic [2:0]       req0_sel,
  input  logic [N-1:0]     req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [2:0]       req1_sel,
  input  logic [N-1:0]     req1_data,
  output logic             req1_ready,
  input  logic [2:0]       read1_sel,
  input  logic [2:0]       read2_sel,
  output logic             wr_en,
  output logic [2:0]       write1_sel,
  output logic [N-1:0]     data_in,
  output logic             raw_hazard,
  output logic [CNT_W-1:0] contention_cnt
);

  logic             last_grant_q, last_grant_d;
  logic             wr_en_q, wr_en_d;
  logic [2:0]       sel_q, sel_d;
  logic [N-1:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt0, gnt1, contend;

  // Readies are gated by rst so nothing handshakes while the block is held in reset.
  always_comb begin
    gnt0    = rst & ~hold & req0_valid & (~req1_valid | last_grant_q);
    gnt1    = rst & ~hold & req1_valid & (~req0_valid | ~last_grant_q);
    contend = req0_valid & req1_valid & ~hold;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    wr_en_d      = gnt0 | gnt1;
    sel_d        = sel_q;
    data_d       = data_q;
    if (gnt0) begin
      last_grant_d = 1'b0;
      sel_d        = req0_sel;
      data_d       = req0_data;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
      sel_d        = req1_sel;
      data_d       = req1_data;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt)                   cnt_d = '0;
    else if (contend && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
      wr_en_q      <= 1'b0;
      sel_q        <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req0_ready     = gnt0;
  assign req1_ready     = gnt1;
  assign wr_en          = wr_en_q;
  assign write1_sel     = sel_q;
  assign data_in        = data_q;
  assign contention_cnt = cnt_q;
  assign raw_hazard     = wr_en_q & ((sel_q == read1_sel) | (sel_q == read2_sel));

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: grant order, output stage, hazard flag, counter, reset.
module tb_regfile_wr_arbiter;
  localparam int N = 16;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst, hold, clr_cnt;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0] req0_sel, req1_sel, read1_sel, read2_sel, write1_sel;
  logic [N-1:0] req0_data, req1_data, data_in;
  logic wr_en, raw_hazard;
  logic [CNT_W-1:0] contention_cnt;

  int tests = 0;
  int fails = 0;
  logic [N-1:0] rf [8];

  always #5 clk = ~clk;

  // Register-file model fed from the write port.
  always @(posedge clk) if (wr_en) rf[write1_sel] <= data_in;

  regfile_wr_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hold(hold), .clr_cnt(clr_cnt),
    .req0_valid(req0_valid), .req0_sel(req0_sel), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_sel(req1_sel), .req1_data(req1_data), .req1_ready(req1_ready),
    .read1_sel(read1_sel), .read2_sel(read2_sel),
    .wr_en(wr_en), .write1_sel(write1_sel), .data_in(data_in),
    .raw_hazard(raw_hazard), .contention_cnt(contention_cnt)
  );

  task automatic apply_reset();
    rst = 1'b0; hold = 1'b0; clr_cnt = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_sel = '0; req1_sel = '0; req0_data = '0; req1_data = '0;
    read1_sel = 3'd7; read2_sel = 3'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; hold = 1'b0; clr_cnt = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_sel = 3'd1; req1_sel = 3'd2; req0_data = 16'h1234; req1_data = 16'h4321;
    read1_sel = 3'd0; read2_sel = 3'd0;
    for (int i = 0; i < 8; i++) rf[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    tests++; if (write1_sel !== 3'd0 || data_in !== 16'h0) begin fails++; $display("FAIL reset_stage got sel=%0d data=%h want 0/0000", write1_sel, data_in); end
    tests++; if (contention_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", contention_cnt); end
    tests++; if (raw_hazard !== 1'b0) begin fails++; $display("FAIL reset_raw got %b want 0", raw_hazard); end
  endtask

  task automatic test_single();
    apply_reset();
    req0_valid = 1'b1; req0_sel = 3'd3; req0_data = 16'hA5A5;
    #1;
    tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    tests++; if (wr_en !== 1'b1 || write1_sel !== 3'd3 || data_in !== 16'hA5A5) begin fails++; $display("FAIL single_write got en=%b sel=%0d data=%h want 1/3/a5a5", wr_en, write1_sel, data_in); end
    @(posedge clk); #1;
    tests++; if (wr_en !== 1'b0 || write1_sel !== 3'd3 || data_in !== 16'hA5A5) begin fails++; $display("FAIL single_drain got en=%b sel=%0d data=%h want 0/3/a5a5", wr_en, write1_sel, data_in); end
    tests++; if (rf[3] !== 16'hA5A5) begin fails++; $display("FAIL single_rf got %h want a5a5", rf[3]); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_d;
    apply_reset();
    req0_valid = 1'b1; req0_sel = 3'd1; req0_data = 16'h1111;
    req1_valid = 1'b1; req1_sel = 3'd4; req1_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin fails++; $display("FAIL fair_ready[%0d] got %b want %b", i, {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      exp_d = (i % 2 == 0) ? 16'h1111 : 16'h2222;
      @(posedge clk); #1;
      tests++; if (wr_en !== 1'b1 || data_in !== exp_d) begin fails++; $display("FAIL fair_write[%0d] got en=%b data=%h want 1/%h", i, wr_en, data_in, exp_d); end
      if (i < 3) @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tests++; if (contention_cnt !== 8'd4) begin fails++; $display("FAIL fair_cnt got %0d want 4", contention_cnt); end
  endtask

  task automatic test_hold();
    apply_reset();
    hold = 1'b1;
    req0_valid = 1'b1; req0_sel = 3'd6; req0_data = 16'hC0DE;
    req1_valid = 1'b1; req1_sel = 3'd7; req1_data = 16'hD00D;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL hold_ready[%0d] got %b want 00", i, {req0_ready, req1_ready}); end
      @(posedge clk); #1;
      tests++; if (wr_en !== 1'b0 || contention_cnt !== 8'd0) begin fails++; $display("FAIL hold_stage[%0d] got en=%b cnt=%0d want 0/0", i, wr_en, contention_cnt); end
      @(negedge clk);
    end
    hold = 1'b0;
    #1;
    tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL hold_release got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tests++; if (wr_en !== 1'b1 || data_in !== 16'hC0DE || contention_cnt !== 8'd1) begin fails++; $display("FAIL hold_after got en=%b data=%h cnt=%0d want 1/c0de/1", wr_en, data_in, contention_cnt); end
  endtask

  task automatic test_collision();
    apply_reset();
    req0_valid = 1'b1; req0_sel = 3'd5; req0_data = 16'd1;
    req1_valid = 1'b1; req1_sel = 3'd5; req1_data = 16'd2;
    #1;
    tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL coll_first got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    tests++; if (wr_en !== 1'b1 || write1_sel !== 3'd5 || data_in !== 16'd1) begin fails++; $display("FAIL coll_w1 got en=%b sel=%0d data=%h want 1/5/0001", wr_en, write1_sel, data_in); end
    #1;
    tests++; if ({req0_ready, req1_ready} !== 2'b01) begin fails++; $display("FAIL coll_second got %b want 01", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    tests++; if (wr_en !== 1'b1 || data_in !== 16'd2) begin fails++; $display("FAIL coll_w2 got en=%b data=%h want 1/0002", wr_en, data_in); end
    @(posedge clk); #1;
    tests++; if (rf[5] !== 16'd2) begin fails++; $display("FAIL coll_rf got %h want 0002", rf[5]); end
  endtask

  task automatic test_raw();
    apply_reset();
    req0_valid = 1'b1; req0_sel = 3'd2; req0_data = 16'hBEEF;
    @(posedge clk); #1;
    req0_valid = 1'b0; read1_sel = 3'd2;
    #1;
    tests++; if (raw_hazard !== 1'b1) begin fails++; $display("FAIL raw_r1 got %b want 1", raw_hazard); end
    @(posedge clk); #1;
    tests++; if (raw_hazard !== 1'b0) begin fails++; $display("FAIL raw_gone got %b want 0", raw_hazard); end
    read1_sel = 3'd7;
    @(negedge clk);
    req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0; read2_sel = 3'd2;
    #1;
    tests++; if (raw_hazard !== 1'b1) begin fails++; $display("FAIL raw_r2 got %b want 1", raw_hazard); end
    read1_sel = 3'd0; read2_sel = 3'd1;
    #1;
    tests++; if (raw_hazard !== 1'b0) begin fails++; $display("FAIL raw_nomatch got %b want 0", raw_hazard); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    apply_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    tests++; if (contention_cnt !== 8'd255) begin fails++; $display("FAIL sat_cnt got %0d want 255", contention_cnt); end
    @(negedge clk);
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    tests++; if (contention_cnt !== 8'd0) begin fails++; $display("FAIL clr_cnt got %0d want 0", contention_cnt); end
    clr_cnt = 1'b0;
    @(posedge clk); #1;
    tests++; if (contention_cnt !== 8'd1) begin fails++; $display("FAIL clr_resume got %0d want 1", contention_cnt); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    req1_valid = 1'b1; req1_sel = 3'd6; req1_data = 16'h5A5A;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    tests++; if (wr_en !== 1'b1 || data_in !== 16'h5A5A) begin fails++; $display("FAIL async_pre got en=%b data=%h want 1/5a5a", wr_en, data_in); end
    #2;
    rst = 1'b0;
    #1;
    tests++; if (wr_en !== 1'b0 || write1_sel !== 3'd0 || data_in !== 16'h0) begin fails++; $display("FAIL async_drop got en=%b sel=%0d data=%h want 0/0/0000", wr_en, write1_sel, data_in); end
    req0_valid = 1'b1;
    #1;
    tests++; if (req0_ready !== 1'b0) begin fails++; $display("FAIL async_ready got %b want 0", req0_ready); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL async_release got %b want 1", req0_ready); end
    req0_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_hold();
    test_collision();
    test_raw();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the 8x16 register file between two write-back requesters, e.g. ALU result and load return.
- Arbitration is round-robin. The winning write goes through one registered output stage that drives the register file's wr_en / write1_sel / data_in.
- Flags a read hazard when a decode-stage read select matches the write still in flight.
- Keeps a saturating count of contention cycles for performance monitoring.

Parameters:
- N, 16, data width of each write request and of the register-file write data.
- CNT_W, 8, width of the contention counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- hold  input  1  when 1, no grants are issued; the output stage still drains.
- clr_cnt  input  1  synchronous clear of contention_cnt.
- req0_valid  input  1  requester 0 has a write pending.
- req0_sel  input  3  requester 0 destination register.
- req0_data  input  N  requester 0 write data.
- req0_ready  output  1  requester 0 granted this cycle (combinational).
- req1_valid  input  1  requester 1 has a write pending.
- req1_sel  input  3  requester 1 destination register.
- req1_data  input  N  requester 1 write data.
- req1_ready  output  1  requester 1 granted this cycle (combinational).
- read1_sel  input  3  decode-stage read port 1 select.
- read2_sel  input  3  decode-stage read port 2 select.
- wr_en  output  1  register-file write enable (registered).
- write1_sel  output  3  register-file write select (registered).
- data_in  output  N  register-file write data (registered).
- raw_hazard  output  1  an in-flight write targets read1_sel or read2_sel.
- contention_cnt  output  CNT_W  saturating count of cycles in which both requesters were valid and neither was blocked by hold.

Behaviour:
- Reset (rst=0, asynchronous): wr_en=0, write1_sel=0, data_in=0, contention_cnt=0, last_grant=1. Ready outputs are 0 while rst=0.
- Handshake: a transfer occurs when reqX_valid=1 and reqX_ready=1. Requesters hold sel/data stable until ready. Ready never asserts without valid.
- Grant rules, evaluated combinationally each cycle:
  - hold=1: both ready=0.
  - Only one requester valid: that requester is granted.
  - Both valid: grant requester (last_grant==1 ? 0 : 1).
  - Neither valid: no grant.
  - At most one ready is ever high.
- last_grant updates to the granted index on every grant; it is unchanged when there is no grant.
- Output stage, every rising edge:
  - wr_en <= (grant occurred).
  - write1_sel/data_in <= granted sel/data.
  - On no grant, write1_sel/data_in hold their previous values and wr_en=0.
- Latency: a granted write appears at the register-file port the cycle after the handshake and is written into the register file on the following edge. There is no backpressure from the register file; one write per cycle is sustained.
- raw_hazard = wr_en & ((write1_sel==read1_sel) | (write1_sel==read2_sel)). This is purely combinational from the output stage and the read selects.
- Same destination from both requesters in one cycle: no special case; round-robin ordering applies. The loser writes the following cycle, so the loser's data is the final register value.
- contention_cnt:
  - Increments by 1 on a cycle with req0_valid & req1_valid & ~hold.
  - Saturates at all-ones.
  - clr_cnt=1 forces 0 that edge; clr_cnt has priority over increment.
- Reset mid-operation: an in-flight write is dropped (wr_en forced 0 immediately). The requester must re-present its write after reset release.

Test Plan:
- Reset then single requester: rst low→high, req0_valid=1, sel=3, data=16'hA5A5 → req0_ready=1 that cycle; next cycle wr_en=1, write1_sel=3, data_in=16'hA5A5; following cycle wr_en=0.
- Contention fairness: both valid continuously for 4 cycles → grants alternate 0,1,0,1 (first to req0 after reset); contention_cnt=4.
- Hold: both valid, hold=1 for 3 cycles → both ready=0, wr_en=0, contention_cnt unchanged; on hold release, req0 gets the first grant.
- Same-destination collision: req0 sel=5 data=1, req1 sel=5 data=2 same cycle, after reset → writes issue in order data 1 then data 2; register 5 ends at 2.
- RAW hazard: grant write to sel=2, with read1_sel=2 in the next cycle → raw_hazard=1 for exactly that cycle; read2_sel=2 alone also gives 1; read sels 0/1 give 0.
- Saturation and async reset: force 300 contention cycles → contention_cnt=255; clr_cnt → 0. Assert rst mid-cycle while wr_en=1 → wr_en drops to 0 without waiting for a clk edge.
